mmio_uart_port: RTL and testbench

- Memory-mapped I/O responder on the processor's data bus (Address/WriteData/MemWrite/MemRead/ReadData), sitting beside the data RAM.
- Gives software three services: a latched 32-bit output port, a synchronized 8-bit input port, and a byte-serial UART transmitter fed from a small FIFO.
- Top level drives PortOut from this block and ORs its ReadData into the memory read path when the block is selected.

---
 rtl/mmio_pkg.sv | 39 +++
 rtl/mmio_uart_port_uart_tx_engine.sv | 124 ++++++++++++
 rtl/mmio_uart_port.sv | 139 +++++++++++++
 tb/tb_mmio_uart_port.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART/port block: register offsets,
// STATUS bit layout and the transmitter state encoding.
package mmio_pkg;

   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_PORTIN  = 2'd2;
   localparam logic [1:0] OFF_PORTOUT = 2'd3;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_EMPTY   = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;
   localparam int STAT_CNT_MSB = 7;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   function automatic logic [31:0] pack_status(input logic       busy,
                                               input logic       full,
                                               input logic       empty,
                                               input logic       ovf,
                                               input logic [3:0] cnt);
      logic [31:0] s;
      s = 32'h0000_0000;
      s[STAT_BUSY]                 = busy;
      s[STAT_FULL]                 = full;
      s[STAT_EMPTY]                = empty;
      s[STAT_OVF]                  = ovf;
      s[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
      return s;
   endfunction

endpackage

// File: rtl/mmio_uart_port_uart_tx_engine.sv
// Byte-serial 8N1 transmitter: pulls bytes from the FIFO head and shifts them
// out LSB first; back-to-back frames chain straight from STOP into START.
module uart_tx_engine #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_valid,
   input  logic [7:0] data,
   output logic       data_pop,
   output logic       Tx,
   output logic       active
);
   import mmio_pkg::*;

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   uart_state_e   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          pop_s;
   logic          baud_last_s;

   assign baud_last_s = (baud_q == BAUD_LAST);

   // State register and datapath flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= UART_IDLE;
         baud_q    <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
      end
   end

   // Next-state, bit sequencing and FIFO pop
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop_s     = 1'b0;
      case (state_q)
         UART_IDLE: begin
            if (data_valid) begin
               pop_s     = 1'b1;
               shift_d   = data;
               bit_idx_d = 3'd0;
               state_d   = UART_START;
            end else begin
               state_d = UART_IDLE;
            end
         end
         UART_START: begin
            if (baud_last_s) begin
               state_d   = UART_DATA;
               bit_idx_d = 3'd0;
            end else begin
               state_d = UART_START;
            end
         end
         UART_DATA: begin
            if (baud_last_s) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = UART_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               state_d = UART_DATA;
            end
         end
         UART_STOP: begin
            if (baud_last_s) begin
               if (data_valid) begin
                  pop_s     = 1'b1;
                  shift_d   = data;
                  bit_idx_d = 3'd0;
                  state_d   = UART_START;
               end else begin
                  state_d = UART_IDLE;
               end
            end else begin
               state_d = UART_STOP;
            end
         end
         default: state_d = UART_IDLE;
      endcase

      // The baud counter restarts on every state change so each bit gets a full period
      if ((state_d != state_q) || (state_q == UART_IDLE) || baud_last_s) begin
         baud_d = '0;
      end else begin
         baud_d = baud_q + BW'(1);
      end
   end

   // Line level registered from the next state so Tx never glitches
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         UART_START: tx_d = 1'b0;
         UART_DATA:  tx_d = shift_d[0];
         UART_IDLE:  tx_d = 1'b1;
         UART_STOP:  tx_d = 1'b1;
         default:    tx_d = 1'b1;
      endcase
   end

   assign data_pop = pop_s;
   assign Tx       = tx_q;
   assign active   = (state_q != UART_IDLE);

endmodule

// File: rtl/mmio_uart_port.sv
// Data-bus MMIO responder: 32-bit output port, synchronized 8-bit input port
// and a FIFO-fed UART transmitter in a 16-byte register window.
module mmio_uart_port #(
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic        Tx,
   output logic        TxBusy
);
   import mmio_pkg::*;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   portout_q, portout_d;
   logic [7:0]    sync1_q, sync2_q;

   logic          sel_s, wr_en_s, push_s, pop_s, push_ok_s;
   logic          full_s, empty_s, ovf_clr_s, active_s, busy_s;
   logic [1:0]    off_s;
   logic [31:0]   status_s, rdata_s;
   logic          unused_addr_bits_s;

   assign sel_s     = (Address[31:4] == BASE_ADDR[31:4]);
   assign off_s     = Address[3:2];
   assign wr_en_s   = sel_s && MemWrite;
   assign push_s    = wr_en_s && (off_s == OFF_TXDATA);
   assign ovf_clr_s = wr_en_s && (off_s == OFF_STATUS) && WriteData[STAT_OVF];
   assign full_s    = (count_q == CW'(FIFO_DEPTH));
   assign empty_s   = (count_q == '0);
   // A full FIFO still accepts a push when the engine pops in the same cycle
   assign push_ok_s = push_s && (!full_s || pop_s);
   assign busy_s    = active_s || !empty_s;
   assign unused_addr_bits_s = ^Address[1:0];

   // FIFO, overflow flag, output port and input synchronizer flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         portout_q <= 32'h0000_0000;
         sync1_q   <= 8'h00;
         sync2_q   <= 8'h00;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         portout_q <= portout_d;
         sync1_q   <= PortIn;
         sync2_q   <= sync1_q;
         if (push_ok_s) begin
            mem_q[wr_ptr_q] <= WriteData[7:0];
         end
      end
   end

   // Next-state for FIFO bookkeeping and writable registers
   always_comb begin
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_ok_s) - CW'(pop_s);
      if (push_s && !push_ok_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      if (wr_en_s && (off_s == OFF_PORTOUT)) begin
         portout_d = WriteData;
      end else begin
         portout_d = portout_q;
      end
   end

   assign status_s = pack_status(busy_s, full_s, empty_s, ovf_q, 4'(count_q));

   // Zero-latency load mux; unselected or non-load cycles return zero
   always_comb begin
      rdata_s = 32'h0000_0000;
      if (sel_s && MemRead) begin
         case (off_s)
            OFF_TXDATA:  rdata_s = 32'h0000_0000;
            OFF_STATUS:  rdata_s = status_s;
            OFF_PORTIN:  rdata_s = {24'h00_0000, sync2_q};
            OFF_PORTOUT: rdata_s = portout_q;
            default:     rdata_s = 32'h0000_0000;
         endcase
      end else begin
         rdata_s = 32'h0000_0000;
      end
   end

   uart_tx_engine #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk       (clk),
      .reset     (reset),
      .data_valid(!empty_s),
      .data      (mem_q[rd_ptr_q]),
      .data_pop  (pop_s),
      .Tx        (Tx),
      .active    (active_s)
   );

   assign ReadData = rdata_s;
   assign PortOut  = portout_q;
   assign TxBusy   = busy_s;

endmodule

// File: tb/tb_mmio_uart_port.sv
// Randomized bench for mmio_uart_port: a frame-level reference model predicts
// register reads and the Tx line; a monitor decodes frames against a scoreboard.
module tb_mmio_uart_port;

   localparam logic [31:0] BASE    = 32'h1001_0000;
   localparam logic [27:0] BASE_HI = 28'h100_1000;
   localparam int          CPB     = 16;
   localparam int          DEPTH   = 4;
   localparam int          FRAME   = 10 * CPB;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] Address = 32'h0;
   logic [31:0] WriteData = 32'h0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [7:0]  PortIn = 8'h00;
   logic [31:0] ReadData;
   logic [31:0] PortOut;
   logic        Tx;
   logic        TxBusy;

   int total = 0;
   int bad   = 0;

   mmio_uart_port #(
      .BASE_ADDR(BASE),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
      .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
      .PortIn(PortIn), .PortOut(PortOut), .Tx(Tx), .TxBusy(TxBusy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame-level) ----------------
   logic [7:0]  m_q[$];
   logic [7:0]  exp_q[$];
   bit          m_busy;
   int          m_rem;
   logic [7:0]  m_cur;
   bit          m_ovf;
   logic [31:0] m_pout;
   logic [7:0]  m_pin_1, m_pin_2;
   bit          m_sel, m_pop;
   logic [1:0]  m_off;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q.delete(); exp_q.delete();
         m_busy = 0; m_rem = 0; m_ovf = 0; m_pout = 32'h0; m_cur = 8'h00;
         m_pin_1 = 8'h00; m_pin_2 = 8'h00;
      end else begin
         m_sel = (Address[31:4] == BASE_HI);
         m_off = Address[3:2];
         // the transmitter takes a byte when idle or in the last cycle of a frame
         m_pop = (m_q.size() > 0) && (!m_busy || m_rem == 1);
         if (m_pop) begin
            m_cur = m_q.pop_front(); m_busy = 1; m_rem = FRAME;
         end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) m_busy = 0;
         end
         if (m_sel && MemWrite) begin
            case (m_off)
               2'd0: if (m_q.size() < DEPTH) begin
                        m_q.push_back(WriteData[7:0]); exp_q.push_back(WriteData[7:0]);
                     end else m_ovf = 1;
               2'd1: if (WriteData[3]) m_ovf = 0;
               2'd3: m_pout = WriteData;
               default: ;
            endcase
         end
         m_pin_2 = m_pin_1;
         m_pin_1 = PortIn;
      end
   end

   function automatic logic m_txbusy();
      return m_busy || (m_q.size() > 0);
   endfunction

   function automatic logic m_tx();
      int p;
      int k;
      if (!m_busy) return 1'b1;
      p = FRAME - m_rem;
      k = p / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_cur[k-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] s;
      if (a[31:4] != BASE_HI) return 32'h0;
      case (a[3:2])
         2'd1: begin
            s = 32'h0;
            s[0]   = m_txbusy();
            s[1]   = (m_q.size() == DEPTH);
            s[2]   = (m_q.size() == 0);
            s[3]   = m_ovf;
            s[7:4] = 4'(m_q.size());
            return s;
         end
         2'd2:    return {24'h0, m_pin_2};
         2'd3:    return m_pout;
         default: return 32'h0;
      endcase
   endfunction

   // ---------------- per-cycle checks and frame monitor ----------------
   bit         mon_act = 0;
   int         mon_cnt = 0;
   logic [7:0] mon_byte = 8'h00;
   logic [7:0] mon_exp;

   always @(negedge clk) begin
      check("tx_line", Tx, m_tx());
      check("txbusy", TxBusy, m_txbusy());
      check("portout", PortOut, m_pout);
      if (!reset) begin
         mon_act = 0;
      end else if (!mon_act) begin
         if (Tx === 1'b0) begin
            mon_act = 1; mon_cnt = 0; mon_byte = 8'h00;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt == CPB/2) begin
            check("start_bit", Tx, 1'b0);
         end else if ((mon_cnt % CPB == CPB/2) && (mon_cnt < 9*CPB)) begin
            mon_byte[mon_cnt/CPB - 1] = Tx;
         end else if (mon_cnt == 9*CPB + CPB/2) begin
            check("stop_bit", Tx, 1'b1);
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL frame_unexpected: got byte %h with no byte queued, required no frame", mon_byte);
            end else begin
               mon_exp = exp_q.pop_front();
               check("frame_byte", mon_byte, mon_exp);
            end
            mon_act = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
      @(posedge clk); #1;
      MemWrite = 1'b0;
   endtask

   task automatic rd(input string name, input logic [31:0] a, input bit has_k, input logic [31:0] k);
      Address = a; MemRead = 1'b1; MemWrite = 1'b0;
      @(negedge clk);
      check(name, ReadData, m_read(a));
      if (has_k) check({name, "_const"}, ReadData, k);
      @(posedge clk); #1;
      MemRead = 1'b0;
   endtask

   initial begin
      int n;
      int r;
      logic [31:0] a;

      cyc(3);
      check("reset_tx", Tx, 1'b1);
      check("reset_busy", TxBusy, 1'b0);
      check("reset_portout", PortOut, 32'h0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      rd("status_reset", BASE + 32'h4, 1, 32'h0000_0004);

      // output port
      wr(BASE + 32'hC, 32'hDEAD_BEEF);
      check("portout_write", PortOut, 32'hDEAD_BEEF);
      rd("portout_read", BASE + 32'hC, 1, 32'hDEAD_BEEF);
      rd("outside_read", BASE + 32'h10, 1, 32'h0);
      rd("txdata_read", BASE + 32'h1, 1, 32'h0);
      Address = BASE + 32'hC; MemRead = 1'b0; #2;
      check("no_memread", ReadData, 32'h0);

      // input synchronizer: 0 edges and 1 edge after the change still read 0
      PortIn = 8'h00; cyc(3);
      PortIn = 8'hA5;
      rd("portin_e0", BASE + 32'h8, 1, 32'h0);
      rd("portin_e1", BASE + 32'h8, 1, 32'h0);
      rd("portin_e2", BASE + 32'hB, 1, 32'h0000_00A5);

      // single byte: idle again FRAME+1 edges after the push edge
      wr(BASE, 32'h55);
      n = 0;
      while (TxBusy && n < 400) begin cyc(1); n++; end
      check("single_busy_len", n, FRAME + 1);

      // back-to-back pushes, then a rejected push on a full FIFO
      for (int i = 1; i <= 5; i++) wr(BASE, i);
      wr(BASE, 32'h06);
      rd("status_ovf", BASE + 32'h4, 1, 32'h0000_004B);
      wr(BASE + 32'h4, 32'h8);
      rd("status_clr", BASE + 32'h4, 1, 32'h0000_0043);

      // push on the STOP->START pop cycle while full
      n = 0;
      while (!(m_busy && m_rem == 1 && m_q.size() == DEPTH) && n < 2000) begin cyc(1); n++; end
      check("stop_pop_found", (n < 2000), 1'b1);
      wr(BASE, 32'hA7);
      rd("status_pushpop", BASE + 32'h4, 1, 32'h0000_0043);

      n = 0;
      while (TxBusy && n < 8*FRAME) begin cyc(1); n++; end
      check("drain1_idle", TxBusy, 1'b0);
      check("drain1_queue", exp_q.size(), 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         PortIn = 8'($urandom);
         a = BASE + {28'h0, 2'($urandom), 2'($urandom)};
         case (r)
            0, 1:    wr(BASE + {30'h0, 2'($urandom)}, $urandom);
            2:       wr(a, $urandom);
            3:       wr(BASE + 32'h4, 32'h8);
            4:       wr(BASE + 32'hC, $urandom);
            5, 6, 7: rd("rand_read", a, 0, 32'h0);
            8:       rd("rand_far", $urandom, 0, 32'h0);
            default: cyc($urandom_range(1, 40));
         endcase
      end
      n = 0;
      while (TxBusy && n < 8*FRAME) begin cyc(1); n++; end
      check("drain2_idle", TxBusy, 1'b0);

      // reset in the middle of a start bit
      wr(BASE + 32'hC, 32'h1234_5678);
      wr(BASE, 32'h0F);
      wr(BASE, 32'hF0);
      n = 0;
      while (Tx !== 1'b0 && n < 50) begin cyc(1); n++; end
      check("wait_start", Tx, 1'b0);
      #3 reset = 1'b0;
      #1;
      check("midreset_tx", Tx, 1'b1);
      check("midreset_busy", TxBusy, 1'b0);
      check("midreset_portout", PortOut, 32'h0);
      cyc(2);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      rd("status_after_reset", BASE + 32'h4, 1, 32'h0000_0004);
      cyc(2 * FRAME);
      check("final_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
